prf_debug_access_ctrl: RTL and testbench
========================================

Name: prf_debug_access_ctrl

Overview:
- Arbitrates two requesters for the physical register file's byte-wide debug port: requester 0 is the debug host, requester 1 is the checkpoint/init loader.
- Converts each full 64-bit register read or write into 8 sequential byte accesses on that port.
- Sits between the core top-level debug logic and the PRF debug address/write-data/write-enable/read-data pins.
- Two-entry round-robin arbitration; one transaction outstanding at a time.

Parameters:
PHYS_LOG, 7, width of physical register index
NUM_PHYS_REG, 96, number of implemented physical registers; indices >= this are rejected
BYTE_OFF, 3, byte-offset bits in the PRF debug address
DATA_W, 64, register width (= 8 << BYTE_OFF... fixed 64)
BYTE_W, 8, PRF debug port data width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid_i  in  2  per-requester request valid
req_we_i  in  2  per-requester 1=write, 0=read
req_addr_i  in  2*PHYS_LOG  per-requester register index, requester r at [r*PHYS_LOG +: PHYS_LOG]
req_wdata_i  in  2*DATA_W  per-requester write data, requester r at [r*DATA_W +: DATA_W]
req_ready_o  out  2  one-hot accept strobe; transfer occurs when valid&ready
rsp_valid_o  out  2  one-cycle completion pulse to the owning requester
rsp_err_o  out  1  qualifies rsp_valid_o; 1 = index out of range
rsp_rdata_o  out  DATA_W  read result; 0 for writes and errors
prf_addr_o  out  PHYS_LOG+BYTE_OFF  PRF debug address {index, byte}
prf_wr_data_o  out  BYTE_W  PRF debug write byte
prf_wr_en_o  out  1  PRF debug write enable
prf_rd_data_i  in  BYTE_W  PRF debug read byte, valid exactly 1 cycle after address
busy_o  out  1  1 in any state other than IDLE

Behaviour:
- Reset (async assert, low): state=IDLE, rr pointer=0, all registered outputs 0. Reset mid-transaction abandons it with no rsp pulse. PRF bytes already written stay written.
- States: IDLE, ACCESS, DRAIN, RESP.
- IDLE:
  - req_ready_o is combinational: grant = valid requester nearest the rr pointer (pointer r means r has priority). Only one bit is ever set.
  - On accept: latch owner, we, addr, and wdata; clear the rdata register; rr pointer <- ~owner.
  - If addr < NUM_PHYS_REG, go to ACCESS with byte counter k=0; otherwise go to RESP with err=1.
- ACCESS (8 cycles, k=0..7):
  - prf_addr_o={addr,k}.
  - Writes: prf_wr_en_o=1 and prf_wr_data_o=wdata[8k+:8] (little-endian).
  - Reads: prf_wr_en_o=0 and prf_wr_data_o=0. At the end of cycle k (k>=1), capture prf_rd_data_i into rdata[8(k-1)+:8].
  - k increments each cycle; after k=7, go to DRAIN.
- DRAIN (1 cycle): prf_addr_o=0 and prf_wr_en_o=0. Reads capture byte 7 at the end of the cycle. Always entered, for reads and writes alike, so latency is uniform.
- RESP (1 cycle): rsp_valid_o[owner]=1 and rsp_err_o=err; rsp_rdata_o=rdata for reads, 0 otherwise. Next state IDLE.
- rsp_rdata_o and rsp_err_o are 0 outside RESP. prf_* outputs are 0 outside ACCESS. req_ready_o is 0 outside IDLE.
- Latency for a valid index: accept at cycle T, ACCESS T+1..T+8, DRAIN T+9, RESP T+10; a new request can be accepted at T+11.
- Latency for an error: accept at T, RESP at T+1.
- Input changes after accept are ignored.
- Simultaneous valid requests are granted by the rr pointer; the loser keeps valid asserted and wins next. There is no starvation: consecutive grants alternate whenever both are valid.
- Boundaries:
  - addr=NUM_PHYS_REG-1 is legal.
  - addr=NUM_PHYS_REG raises err.
  - addr=2^PHYS_LOG-1 raises err, with no PRF activity.

Test Plan:
- Reset, then req0 write addr=5, wdata=0x8877665544332211 -> prf_wr_en_o high T+1..T+8; prf_addr_o 0x28..0x2F; bytes 0x11..0x88 in order; rsp_valid_o=2'b01 at T+10; rsp_err_o=0; rsp_rdata_o=0.
- req1 read addr=5 with PRF model returning the written bytes at 1-cycle latency -> prf_wr_en_o=0 throughout; rsp_valid_o=2'b10 at T+10; rsp_rdata_o=0x8877665544332211.
- Both valid, continuously, from reset -> grants ordered 0,1,0,1; each accept 11 cycles apart; no ready in non-IDLE cycles.
- req0 read addr=96 (NUM_PHYS_REG) -> rsp_valid_o=2'b01 and rsp_err_o=1 at T+1; rsp_rdata_o=0; no prf_addr_o/prf_wr_en_o activity. addr=95 completes normally.
- Write in progress, reset asserted low at T+4 -> all outputs 0 immediately; no rsp_valid_o; after release, state is IDLE and req0 is preferred.
- Write addr=3, then read addr=3 issued on the first IDLE cycle after RESP -> accepted at T+11; the read returns the written data.

Source files
------------

// File: rtl/prf_debug_access_ctrl.sv
// Byte-serial debug access controller for the physical register file.
// Two requesters are arbitrated round-robin; each 64-bit access becomes 8 byte accesses.
//
// state  | meaning
// IDLE   | waiting for a request, ready driven combinationally from the grant
// ACCESS | issuing byte k=0..7 on the PRF debug port
// DRAIN  | port idle, read data for byte 7 arrives
// RESP   | one-cycle completion pulse to the owner
module prf_debug_access_ctrl #(
  parameter int unsigned PHYS_LOG     = 7,
  parameter int unsigned NUM_PHYS_REG = 96,
  parameter int unsigned BYTE_OFF     = 3,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned BYTE_W       = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   req_valid_i,
  input  logic [1:0]                   req_we_i,
  input  logic [2*PHYS_LOG-1:0]        req_addr_i,
  input  logic [2*DATA_W-1:0]          req_wdata_i,
  output logic [1:0]                   req_ready_o,
  output logic [1:0]                   rsp_valid_o,
  output logic                         rsp_err_o,
  output logic [DATA_W-1:0]            rsp_rdata_o,
  output logic [PHYS_LOG+BYTE_OFF-1:0] prf_addr_o,
  output logic [BYTE_W-1:0]            prf_wr_data_o,
  output logic                         prf_wr_en_o,
  input  logic [BYTE_W-1:0]            prf_rd_data_i,
  output logic                         busy_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, RESP} state_t;

  state_t                state_q, state_d;
  logic                  rr_q;
  logic                  owner_q;
  logic                  we_q;
  logic                  err_q;
  logic [PHYS_LOG-1:0]   addr_q;
  logic [BYTE_OFF-1:0]   k_q;
  logic [BYTE_OFF-1:0]   k_prev;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     rdata_q;

  logic [1:0]            grant;
  logic                  sel;
  logic                  sel_we;
  logic [PHYS_LOG-1:0]   sel_addr;
  logic [DATA_W-1:0]     sel_wdata;
  logic                  sel_ok;

  // rr_q names the requester holding priority this round.
  always_comb begin
    grant = 2'b00;
    if (state_q == IDLE) begin
      if (!rr_q) begin
        if (req_valid_i[0])      grant = 2'b01;
        else if (req_valid_i[1]) grant = 2'b10;
      end else begin
        if (req_valid_i[1])      grant = 2'b10;
        else if (req_valid_i[0]) grant = 2'b01;
      end
    end
  end

  assign sel       = grant[1];
  assign sel_we    = sel ? req_we_i[1] : req_we_i[0];
  assign sel_addr  = sel ? req_addr_i[2*PHYS_LOG-1:PHYS_LOG] : req_addr_i[PHYS_LOG-1:0];
  assign sel_wdata = sel ? req_wdata_i[2*DATA_W-1:DATA_W] : req_wdata_i[DATA_W-1:0];
  assign sel_ok    = (32'(sel_addr) < NUM_PHYS_REG);
  assign k_prev    = k_q - 1'b1;

  always_comb begin
    state_d       = state_q;
    req_ready_o   = grant;
    rsp_valid_o   = 2'b00;
    rsp_err_o     = 1'b0;
    rsp_rdata_o   = '0;
    prf_addr_o    = '0;
    prf_wr_data_o = '0;
    prf_wr_en_o   = 1'b0;
    busy_o        = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (grant != 2'b00) state_d = sel_ok ? ACCESS : RESP;
      end
      ACCESS: begin
        prf_addr_o  = {addr_q, k_q};
        prf_wr_en_o = we_q;
        if (we_q) prf_wr_data_o = wdata_q[{k_q, 3'b000} +: BYTE_W];
        if (&k_q) state_d = DRAIN;
      end
      DRAIN: state_d = RESP;
      RESP: begin
        rsp_valid_o = owner_q ? 2'b10 : 2'b01;
        rsp_err_o   = err_q;
        if (!we_q && !err_q) rsp_rdata_o = rdata_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      k_q     <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (grant != 2'b00) begin
            owner_q <= sel;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            rdata_q <= '0;
            err_q   <= ~sel_ok;
            rr_q    <= ~sel;
            k_q     <= '0;
          end
        end
        ACCESS: begin
          k_q <= k_q + 1'b1;
          // Read byte for address k-1 arrives during cycle k.
          if (!we_q && (k_q != '0)) rdata_q[{k_prev, 3'b000} +: BYTE_W] <= prf_rd_data_i;
        end
        DRAIN: begin
          if (!we_q) rdata_q[DATA_W-BYTE_W +: BYTE_W] <= prf_rd_data_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prf_debug_access_ctrl.sv
// Directed bench for prf_debug_access_ctrl with a byte-wide PRF model (1-cycle read latency).
module tb_prf_debug_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_we_i;
  logic [13:0] req_addr_i;
  logic [127:0] req_wdata_i;
  logic [1:0]  req_ready_o;
  logic [1:0]  rsp_valid_o;
  logic        rsp_err_o;
  logic [63:0] rsp_rdata_o;
  logic [9:0]  prf_addr_o;
  logic [7:0]  prf_wr_data_o;
  logic        prf_wr_en_o;
  logic [7:0]  prf_rd_data_i;
  logic        busy_o;

  logic [7:0]  mem [0:1023];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;

  prf_debug_access_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o),
    .rsp_err_o(rsp_err_o), .rsp_rdata_o(rsp_rdata_o),
    .prf_addr_o(prf_addr_o), .prf_wr_data_o(prf_wr_data_o),
    .prf_wr_en_o(prf_wr_en_o), .prf_rd_data_i(prf_rd_data_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (prf_wr_en_o) mem[prf_addr_o] <= prf_wr_data_o;
    prf_rd_data_i <= mem[prf_addr_o];
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Issue one request from requester r and check every cycle up to the first IDLE cycle after RESP.
  task automatic do_txn(input int r, input bit we, input logic [6:0] addr,
                        input logic [63:0] wdata, input bit exp_err, input logic [63:0] exp_rdata);
    logic [1:0] onehot;
    onehot = (r == 0) ? 2'b01 : 2'b10;
    req_valid_i = onehot;
    req_we_i[r] = we;
    req_addr_i[r*7 +: 7] = addr;
    req_wdata_i[r*64 +: 64] = wdata;
    #1;
    check_eq("ready_idle", 64'(req_ready_o), 64'(onehot));
    tick();
    req_valid_i = 2'b00;
    req_we_i[r] = ~we;
    req_addr_i[r*7 +: 7] = ~addr;
    req_wdata_i[r*64 +: 64] = ~wdata;
    if (!exp_err) begin
      for (int k = 0; k < 8; k++) begin
        check_eq("acc_addr", 64'(prf_addr_o), 64'({addr, 3'(k)}));
        check_eq("acc_we", 64'(prf_wr_en_o), 64'(we));
        check_eq("acc_wdata", 64'(prf_wr_data_o), we ? 64'(wdata[k*8 +: 8]) : 64'd0);
        check_eq("acc_ready", 64'(req_ready_o), 64'd0);
        check_eq("acc_rsp", 64'(rsp_valid_o), 64'd0);
        tick();
      end
      check_eq("drain_addr", 64'(prf_addr_o), 64'd0);
      check_eq("drain_we", 64'(prf_wr_en_o), 64'd0);
      check_eq("drain_busy", 64'(busy_o), 64'd1);
      tick();
    end
    check_eq("rsp_valid", 64'(rsp_valid_o), 64'(onehot));
    check_eq("rsp_err", 64'(rsp_err_o), 64'(exp_err));
    check_eq("rsp_rdata", rsp_rdata_o, exp_rdata);
    check_eq("rsp_prf_addr", 64'(prf_addr_o), 64'd0);
    check_eq("rsp_prf_we", 64'(prf_wr_en_o), 64'd0);
    check_eq("rsp_ready", 64'(req_ready_o), 64'd0);
    tick();
    check_eq("idle_busy", 64'(busy_o), 64'd0);
    check_eq("idle_rsp", 64'(rsp_valid_o), 64'd0);
  endtask

  initial begin
    logic [1:0] exp_g;
    int last_cyc;
    int viol;
    int c;

    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    reset = 1'b0;
    req_valid_i = 2'b00;
    req_we_i = 2'b00;
    req_addr_i = '0;
    req_wdata_i = '0;
    #2;
    check_eq("rst_busy", 64'(busy_o), 64'd0);
    check_eq("rst_rsp", 64'(rsp_valid_o), 64'd0);
    check_eq("rst_prf_addr", 64'(prf_addr_o), 64'd0);
    tick(); tick();
    reset = 1'b1;
    tick();
    check_eq("rst_ready", 64'(req_ready_o), 64'd0);

    do_txn(0, 1'b1, 7'd5, 64'h8877665544332211, 1'b0, 64'd0);
    do_txn(1, 1'b0, 7'd5, 64'hDEADBEEFDEADBEEF, 1'b0, 64'h8877665544332211);
    do_txn(0, 1'b0, 7'd96, 64'd0, 1'b1, 64'd0);
    do_txn(1, 1'b1, 7'd127, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'd0);
    do_txn(0, 1'b1, 7'd95, 64'h0123456789ABCDEF, 1'b0, 64'd0);
    do_txn(1, 1'b0, 7'd95, 64'd0, 1'b0, 64'h0123456789ABCDEF);
    do_txn(0, 1'b1, 7'd3, 64'hCAFEF00D12345678, 1'b0, 64'd0);
    do_txn(0, 1'b0, 7'd3, 64'd0, 1'b0, 64'hCAFEF00D12345678);
    check_eq("err_no_write", 64'(mem[10'h3F8]), 64'd0);

    // Both requesters valid continuously from reset: grants 0,1,0,1 every 11 cycles.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    req_we_i = 2'b00;
    req_addr_i = {7'd11, 7'd10};
    req_valid_i = 2'b11;
    #1;
    viol = 0;
    last_cyc = 0;
    for (int g = 0; g < 4; g++) begin
      exp_g = (g % 2 == 0) ? 2'b01 : 2'b10;
      c = 0;
      while (req_ready_o == 2'b00 && c < 20) begin
        if (busy_o && req_ready_o != 2'b00) viol++;
        tick();
        c++;
      end
      check_eq("arb_grant", 64'(req_ready_o), 64'(exp_g));
      if (g > 0) check_eq("arb_spacing", 64'(cyc - last_cyc), 64'd11);
      last_cyc = cyc;
      tick();
      if (busy_o && req_ready_o != 2'b00) viol++;
    end
    req_valid_i = 2'b00;
    c = 0;
    while (busy_o && c < 20) begin
      if (req_ready_o != 2'b00) viol++;
      tick();
      c++;
    end
    check_eq("arb_no_ready_busy", 64'(viol), 64'd0);
    check_eq("arb_drained", 64'(busy_o), 64'd0);

    // Reset in the middle of a write: bytes 0..2 land, no response.
    req_valid_i = 2'b01;
    req_we_i = 2'b01;
    req_addr_i = {7'd0, 7'd7};
    req_wdata_i = {64'd0, 64'hA1A2A3A4A5A6A7A8};
    #1;
    check_eq("mid_ready", 64'(req_ready_o), 64'd1);
    tick();
    req_valid_i = 2'b00;
    tick(); tick(); tick();
    check_eq("mid_pre_we", 64'(prf_wr_en_o), 64'd1);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_we", 64'(prf_wr_en_o), 64'd0);
    check_eq("mid_rst_addr", 64'(prf_addr_o), 64'd0);
    check_eq("mid_rst_data", 64'(prf_wr_data_o), 64'd0);
    check_eq("mid_rst_busy", 64'(busy_o), 64'd0);
    check_eq("mid_rst_rsp", 64'(rsp_valid_o), 64'd0);
    tick(); tick();
    check_eq("mid_rst_rsp2", 64'(rsp_valid_o), 64'd0);
    reset = 1'b1;
    tick();
    check_eq("mid_post_rsp", 64'(rsp_valid_o), 64'd0);
    req_valid_i = 2'b11;
    #1;
    check_eq("mid_post_pref", 64'(req_ready_o), 64'd1);
    req_valid_i = 2'b00;
    do_txn(1, 1'b0, 7'd7, 64'd0, 1'b0, 64'h0000000000A6A7A8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
